// File: rtl/hand_walker_if.sv
// hand_walker_if: start/head, card RAM read bus and card stream of the hand walker.
// HAND_WALKER_SUM_EN adds the rank_sum output.
interface hand_walker_if #(
    parameter int ADDR_W = 10,
    parameter int CARD_W = 6
);
    logic                     start;
    logic [ADDR_W-1:0]        head_addr;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_rd;
    logic [CARD_W+ADDR_W-1:0] mem_rdata;
    logic [CARD_W-1:0]        card;
    logic                     card_valid;
    logic                     card_ready;
    logic [5:0]               count;
    logic                     busy;
    logic                     done;
    logic                     err;
`ifdef HAND_WALKER_SUM_EN
    logic [9:0]               rank_sum;
`endif
    modport slave (
`ifdef HAND_WALKER_SUM_EN
        output rank_sum,
`endif
        input  start, head_addr, mem_rdata, card_ready,
        output mem_addr, mem_rd, card, card_valid, count, busy, done, err
    );
    modport master (
`ifdef HAND_WALKER_SUM_EN
        input  rank_sum,
`endif
        output start, head_addr, mem_rdata, card_ready,
        input  mem_addr, mem_rd, card, card_valid, count, busy, done, err
    );
endinterface

// File: rtl/hand_walker.sv
// hand_walker: walks a hand's linked list in card RAM and streams its cards out.
// HAND_WALKER_SUM_EN adds a running rank_sum of accepted cards.
module hand_walker #(
    parameter int                ADDR_W    = 10,
    parameter int                CARD_W    = 6,
    parameter logic [ADDR_W-1:0] NULL_ADDR = 10'h3FF,
    parameter int                MAX_CARDS = 52
) (
    input logic          clk,
    input logic          resetn,
    hand_walker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, FIN} state_t;
    localparam logic [5:0] LAST = 6'(MAX_CARDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CARD_W-1:0] card_q, card_d;
    logic [5:0]        count_q, count_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              go, accept;

    assign go             = state_q == IDLE && bus.start;
    assign accept         = state_q == EMIT && bus.card_ready;
    assign bus.mem_addr   = ptr_q;
    assign bus.mem_rd     = state_q == FETCH;
    assign bus.card       = card_q;
    assign bus.card_valid = state_q == EMIT;
    assign bus.count      = count_q;
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        card_d  = card_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                ptr_d   = bus.head_addr;
                count_d = '0;
                err_d   = 1'b0;
                state_d = bus.head_addr == NULL_ADDR ? FIN : FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                card_d  = bus.mem_rdata[CARD_W+ADDR_W-1:ADDR_W];
                ptr_d   = bus.mem_rdata[ADDR_W-1:0];
                state_d = EMIT;
            end
            EMIT: if (bus.card_ready) begin
                count_d = count_q == 6'(MAX_CARDS) ? count_q : count_q + 6'd1;
                // a list still pointing onward after MAX_CARDS cards must contain a loop
                err_d   = ptr_q != NULL_ADDR && count_q == LAST;
                state_d = ptr_q == NULL_ADDR || count_q == LAST ? FIN : FETCH;
            end
            FIN: begin
                done_d  = !err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            card_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            card_q  <= card_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef HAND_WALKER_SUM_EN
    logic [9:0] sum_q, sum_d;
    assign bus.rank_sum = sum_q;
    always_comb sum_d = go ? '0 : accept ? sum_q + {6'd0, card_q[3:0]} : sum_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sum_q <= '0;
        else sum_q <= sum_d;
    end
`else
    logic unused_go;
    assign unused_go = go ^ accept;
`endif
endmodule
